// File: rtl/instr_prefetch.sv
// Sequential instruction prefetcher: credit-limited fetch into a DEPTH-entry {pc, instr} FIFO with redirect flush.
// Optional stall counter port enabled by defining INSTR_PREFETCH_STALL_COUNT_EN.
module instr_prefetch #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned DEPTH      = 4,
    parameter logic [WORD_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic [WORD_WIDTH-1:0] mem_addr,
    input  logic [WORD_WIDTH-1:0] mem_data,
    input  logic                  redirect,
    input  logic [WORD_WIDTH-1:0] redirect_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_instr,
    output logic [WORD_WIDTH-1:0] out_pc
`ifdef INSTR_PREFETCH_STALL_COUNT_EN
    ,
    output logic [31:0]           stall_count
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WORD_WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic [WORD_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

    logic [WORD_WIDTH-1:0] fifo_pc_q    [DEPTH];
    logic [WORD_WIDTH-1:0] fifo_instr_q [DEPTH];

    logic             pop;
    logic             push;
    logic [CNT_W:0]   occupancy;

    assign out_valid = (count_q != '0);
    assign out_instr = fifo_instr_q[rd_ptr_q];
    assign out_pc    = fifo_pc_q[rd_ptr_q];
    assign pop       = out_valid && out_ready;
    assign push      = inflight_q && !redirect;
    assign mem_addr  = pc_q;

    // Credit counts the in-flight word so its response always has a free slot.
    always_comb begin
        occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
        mem_req   = !reset && !redirect && (occupancy < (CNT_W+1)'(DEPTH));
    end

    always_comb begin
        pc_d          = pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (reset) begin
            pc_d     = RESET_ADDR;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (redirect) begin
            pc_d     = redirect_addr;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (mem_req) begin
                pc_d          = pc_q + WORD_WIDTH'(1);
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        pc_q          <= pc_d;
        rd_ptr_q      <= rd_ptr_d;
        wr_ptr_q      <= wr_ptr_d;
        count_q       <= count_d;
        inflight_q    <= inflight_d;
        inflight_pc_q <= inflight_pc_d;
    end

    // Storage is not reset; out_instr/out_pc are only meaningful while out_valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
            fifo_instr_q[wr_ptr_q] <= mem_data;
        end
    end

`ifdef INSTR_PREFETCH_STALL_COUNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (reset) begin
            stall_count_d = '0;
        end else if (!out_valid && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
`endif

endmodule
